// File: rtl/vga_plot_sink_if.sv
// Plot input (x, y, colour, strobe) and raster scan output (valid/ready) of the plot sink.
// Plots are fire-and-forget with no back-pressure; scan pixels are held while scan_ready is low.
interface vga_plot_sink_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       scan_start;
    logic       scan_ready;
    logic       scan_valid;
    logic [7:0] scan_x;
    logic [6:0] scan_y;
    logic [2:0] scan_colour;
    logic       scan_done;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, scan_start, scan_ready,
        input  scan_valid, scan_x, scan_y, scan_colour, scan_done
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, scan_start, scan_ready,
        output scan_valid, scan_x, scan_y, scan_colour, scan_done
    );
endinterface

// File: rtl/vga_plot_sink.sv
// Plot FIFO -> WIDTH x HEIGHT x 3-bit framebuffer with raster readback; plot lands in RAM 1 cycle after
// acceptance, scan pixel 1 cycle after its read; plots never stall (dropped when full). PLOT_CHECKSUM_EN adds plot_checksum.
module vga_plot_sink #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    vga_plot_sink_if.slave   bus,
    output logic             busy,
    output logic [15:0]      plot_count,
    output logic [7:0]       drop_count
`ifdef PLOT_CHECKSUM_EN
    ,
    output logic [15:0]      plot_checksum
`endif
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = $clog2(NPIX);
    localparam int PW   = $clog2(FIFO_DEPTH);

    localparam logic [8:0]    X_LIM     = 9'(WIDTH);
    localparam logic [7:0]    Y_LIM     = 8'(HEIGHT);
    localparam logic [7:0]    X_LAST    = 8'(WIDTH - 1);
    localparam logic [6:0]    Y_LAST    = 7'(HEIGHT - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NPIX - 1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCAN} state_t;

    typedef struct packed {
        logic [6:0] y;
        logic [7:0] x;
        logic [2:0] c;
    } plot_t;

    typedef logic [PW:0] ptr_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      rx_q, rx_d;
    logic [6:0]      ry_q, ry_d;
    logic            rd_all_q, rd_all_d;
    logic            vld_q, vld_d;
    logic [7:0]      sx_q, sx_d;
    logic [6:0]      sy_q, sy_d;
    logic [2:0]      col_q;
    logic            done_q, done_d;
    ptr_t            wr_ptr_q, rd_ptr_q;
    logic [15:0]     plot_count_q;
    logic [7:0]      drop_count_q;

    plot_t           fifo_q [FIFO_DEPTH];
    logic [2:0]      mem_q  [NPIX];

    plot_t           head;
    logic            empty, full, in_range, push, pop, drop, accept;
    logic            ram_we, ram_re;
    logic [AW-1:0]   ram_addr, wr_addr;
    logic [2:0]      ram_wdat;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign in_range = ({1'b0, bus.vga_x} < X_LIM) && ({1'b0, bus.vga_y} < Y_LIM);
    assign pop      = (state_q != S_CLEAR) && !empty;
    assign push     = bus.vga_plot && in_range && (!full || pop);
    assign drop     = bus.vga_plot && !push;
    assign head     = fifo_q[rd_ptr_q[PW-1:0]];
    assign wr_addr  = AW'(head.y) * AW'(WIDTH) + AW'(head.x);
    assign accept   = vld_q && bus.scan_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        rd_all_d = rd_all_q;
        vld_d    = vld_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        done_d   = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = addr_q;
        ram_wdat = 3'd0;

        // The single RAM port: FIFO drain always wins over a scan read.
        if (pop) begin
            ram_we   = 1'b1;
            ram_addr = wr_addr;
            ram_wdat = head.c;
        end

        case (state_q)
            S_CLEAR: begin
                ram_we = 1'b1;
                addr_d = addr_q + AW'(1);
                if (addr_q == ADDR_LAST) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
            end
            S_IDLE: begin
                if (bus.scan_start) begin
                    state_d  = S_SCAN;
                    addr_d   = '0;
                    rx_d     = '0;
                    ry_d     = '0;
                    rd_all_d = 1'b0;
                end
            end
            S_SCAN: begin
                if (accept) begin
                    vld_d = 1'b0;
                    if (sx_q == X_LAST && sy_q == Y_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                if (empty && !rd_all_q && (!vld_q || bus.scan_ready)) begin
                    ram_re = 1'b1;
                    vld_d  = 1'b1;
                    sx_d   = rx_q;
                    sy_d   = ry_q;
                    addr_d = addr_q + AW'(1);
                    if (rx_q == X_LAST) begin
                        rx_d = '0;
                        ry_d = ry_q + 7'd1;
                        if (ry_q == Y_LAST) begin
                            rd_all_d = 1'b1;
                        end
                    end else begin
                        rx_d = rx_q + 8'd1;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            addr_q       <= '0;
            rx_q         <= '0;
            ry_q         <= '0;
            rd_all_q     <= 1'b0;
            vld_q        <= 1'b0;
            sx_q         <= '0;
            sy_q         <= '0;
            col_q        <= '0;
            done_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            plot_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            rd_all_q <= rd_all_d;
            vld_q    <= vld_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            done_q   <= done_d;
            if (ram_re) begin
                col_q <= mem_q[ram_addr];
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + ptr_t'(1);
                plot_count_q <= plot_count_q + 16'd1;
            end
            if (drop && drop_count_q != 8'hFF) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= '{y: bus.vga_y, x: bus.vga_x, c: bus.vga_colour};
        end
        if (ram_we) begin
            mem_q[ram_addr] <= ram_wdat;
        end
    end

`ifdef PLOT_CHECKSUM_EN
    logic [15:0] chk_q, chk_d;

    assign chk_d = {chk_q[14:0], chk_q[15]} ^ {head.y[4:0], head.x, head.c};

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= '0;
        end else if (pop) begin
            chk_q <= chk_d;
        end
    end

    assign plot_checksum = chk_q;
`endif

    assign busy            = (state_q != S_IDLE);
    assign plot_count      = plot_count_q;
    assign drop_count      = drop_count_q;
    assign bus.scan_valid  = vld_q;
    assign bus.scan_x      = sx_q;
    assign bus.scan_y      = sy_q;
    assign bus.scan_colour = col_q;
    assign bus.scan_done   = done_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Bench for vga_plot_sink on an 8x4 framebuffer: a model framebuffer feeds an expected-pixel queue
// at each scan request, and every accepted scan pixel is popped and compared.
module tb_vga_plot_sink;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] plot_count;
    logic [7:0]  drop_count;
`ifdef PLOT_CHECKSUM_EN
    logic [15:0] plot_checksum;
`endif

    vga_plot_sink_if bus ();

    vga_plot_sink #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .plot_count (plot_count),
        .drop_count (drop_count)
`ifdef PLOT_CHECKSUM_EN
        ,
        .plot_checksum (plot_checksum)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] fb [NPIX];
    int         exp_plot = 0;
    int         exp_drop = 0;
    pix_t       exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NPIX; i++) fb[i] = 3'd0;
        exp_plot = 0;
        exp_drop = 0;
        exp_q.delete();
    endtask

    task automatic plot(input int x, input int y, input int c);
        bus.vga_x      = 8'(x);
        bus.vga_y      = 7'(y);
        bus.vga_colour = 3'(c);
        bus.vga_plot   = 1'b1;
        tick();
        bus.vga_plot   = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic check_counts(input string tag);
        n_checks++;
        if (plot_count !== 16'(exp_plot)) begin
            n_fail++;
            $display("FAIL %s plot_count: got %0d want %0d", tag, plot_count, exp_plot);
        end
        n_checks++;
        if (drop_count !== 8'(exp_drop)) begin
            n_fail++;
            $display("FAIL %s drop_count: got %0d want %0d", tag, drop_count, exp_drop);
        end
    endtask

    // stall_idx / rst_idx < 0 disable the stall and the mid-scan reset respectively.
    task automatic run_scan(input string tag, input int stall_idx, input int rst_idx);
        int   accepted = 0;
        int   dones    = 0;
        int   budget   = 0;
        bit   aborted  = 1'b0;
        bit   stalled  = 1'b0;
        pix_t got, e;
        int   n;
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back('{x: 8'(i % W), y: 7'(i / W), c: fb[i]});
        end
        bus.scan_ready = 1'b1;
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        while ((accepted < NPIX || dones == 0) && budget < 400 && !aborted) begin
            if (bus.scan_done) dones++;
            got = '{x: bus.scan_x, y: bus.scan_y, c: bus.scan_colour};
            if (bus.scan_valid && accepted == rst_idx) begin
                rst     = 1'b1;
                aborted = 1'b1;
            end else if (bus.scan_valid && accepted == stall_idx && !stalled) begin
                stalled        = 1'b1;
                bus.scan_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    bus.scan_start = (k == 0);
                    n_checks++;
                    if (!bus.scan_valid || bus.scan_x !== 8'(stall_idx % W) ||
                        bus.scan_y !== 7'(stall_idx / W) || bus.scan_colour !== fb[stall_idx]) begin
                        n_fail++;
                        $display("FAIL %s stall hold %0d: got v=%b (%0d,%0d,%0d) want v=1 (%0d,%0d,%0d)",
                                 tag, k, bus.scan_valid, bus.scan_x, bus.scan_y, bus.scan_colour,
                                 stall_idx % W, stall_idx / W, fb[stall_idx]);
                    end
                end
                bus.scan_start = 1'b0;
                bus.scan_ready = 1'b1;
                got = '{x: bus.scan_x, y: bus.scan_y, c: bus.scan_colour};
            end
            if (!aborted && bus.scan_valid && bus.scan_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra pixel: got (%0d,%0d,%0d) want none", tag, got.x, got.y, got.c);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL %s pixel %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                                 tag, accepted, got.x, got.y, got.c, e.x, e.y, e.c);
                    end
                end
                accepted++;
            end
            tick();
            budget++;
        end
        if (budget >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d pixels want %0d", tag, accepted, NPIX);
        end
        if (aborted) begin
            tick();
            rst = 1'b0;
            model_reset();
            n_checks++;
            if (bus.scan_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s after reset: got valid=%b busy=%b want valid=0 busy=1", tag, bus.scan_valid, busy);
            end
            check_counts({tag, " after reset"});
            wait_clear(n);
            n_checks++;
            if (n != NPIX) begin
                n_fail++;
                $display("FAIL %s clear rerun: got %0d cycles want %0d", tag, n, NPIX);
            end
        end else begin
            n_checks++;
            if (accepted != NPIX || dones != 1) begin
                n_fail++;
                $display("FAIL %s totals: got %0d pixels %0d done want %0d pixels 1 done", tag, accepted, dones, NPIX);
            end
            tick();
            n_checks++;
            if (bus.scan_done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after done: got done=%b busy=%b want done=0 busy=0", tag, bus.scan_done, busy);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        tick();
        model_reset();
        n_checks++;
        if (bus.scan_valid !== 1'b0 || bus.scan_done !== 1'b0 || busy !== 1'b1 ||
            bus.scan_x !== 8'd0 || bus.scan_y !== 7'd0 || bus.scan_colour !== 3'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got v=%b d=%b busy=%b (%0d,%0d,%0d) want v=0 d=0 busy=1 (0,0,0)",
                     bus.scan_valid, bus.scan_done, busy, bus.scan_x, bus.scan_y, bus.scan_colour);
        end
        check_counts("reset");
        rst = 1'b0;
        wait_clear(n);
        n_checks++;
        if (n != NPIX) begin
            n_fail++;
            $display("FAIL clear length: got %0d cycles want %0d", n, NPIX);
        end
        run_scan("blank", -1, -1);
    endtask

    task automatic test_single_plot();
        plot(3, 2, 5);
        fb[19] = 3'd5;
        exp_plot++;
        tick();
        tick();
        check_counts("single");
        run_scan("single", -1, -1);
    endtask

    task automatic test_out_of_range();
        plot(8, 0, 7);
        plot(0, 4, 7);
        exp_drop += 2;
        tick();
        tick();
        check_counts("range");
        run_scan("range", -1, -1);
    endtask

    task automatic test_clear_overflow();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        plot(4, 0, 1);
        plot(5, 0, 2);
        plot(6, 0, 3);
        plot(7, 0, 4);
        plot(0, 1, 6);
        plot(1, 1, 7);
        fb[4] = 3'd1;
        fb[5] = 3'd2;
        fb[6] = 3'd3;
        fb[7] = 3'd4;
        exp_plot = 4;
        exp_drop = 2;
        wait_clear(n);
        n_checks++;
        if (n != NPIX - 6) begin
            n_fail++;
            $display("FAIL overflow clear tail: got %0d cycles want %0d", n, NPIX - 6);
        end
        for (int i = 0; i < 6; i++) tick();
        check_counts("overflow");
        run_scan("overflow", -1, -1);
    endtask

    task automatic test_backpressure();
        run_scan("stall", 5, -1);
    endtask

    task automatic test_reset_mid_scan();
        run_scan("midrst", -1, 10);
        plot(1, 1, 1);
        fb[9] = 3'd1;
        exp_plot = 1;
        tick();
        tick();
        check_counts("post reset plot");
`ifdef PLOT_CHECKSUM_EN
        n_checks++;
        if (plot_checksum !== 16'h0809) begin
            n_fail++;
            $display("FAIL checksum: got %h want 0809", plot_checksum);
        end
`endif
        run_scan("post reset", -1, -1);
    endtask

    initial begin
        bus.vga_x      = 8'd0;
        bus.vga_y      = 7'd0;
        bus.vga_colour = 3'd0;
        bus.vga_plot   = 1'b0;
        bus.scan_start = 1'b0;
        bus.scan_ready = 1'b1;
        test_reset();
        test_single_plot();
        test_out_of_range();
        test_clear_overflow();
        test_backpressure();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
